// File: rtl/mnist_pkg.sv
// Shared types and defaults for the MNIST binarized classifier controller.
//   state_t   : sequencer FSM states
//   *_DEF     : default frame/class/weight/threshold parameters
//   acc_width : signed accumulator width that cannot overflow for a full frame
package mnist_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

  localparam int unsigned N_PIX_DEF   = 64;
  localparam int unsigned N_CLASS_DEF = 10;
  localparam int unsigned W_W_DEF     = 4;
  localparam int unsigned THRESH_DEF  = 128;

  // Weight width plus enough headroom bits to sum n_pix weights.
  function automatic int unsigned acc_width(input int unsigned w_w, input int unsigned n_pix);
    return w_w + $clog2(n_pix + 1);
  endfunction

endpackage

// File: rtl/mnist_argmax_tracker.sv
// Running argmax over per-class scores.
//   clk, rst   : clock, async active-high reset
//   init       : current compare is class 0, taken unconditionally
//   cmp_en     : a class score is presented this cycle
//   score, idx : class score (signed) and its class index
//   best_idx   : index of the best class so far (registered)
//   best_score : best score so far (only with MNIST_SCORE_OUT_EN)
module mnist_argmax_tracker #(
  parameter int unsigned ACC_W = 11,
  parameter int unsigned IDX_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init,
  input  logic                    cmp_en,
  input  logic signed [ACC_W-1:0] score,
  input  logic [IDX_W-1:0]        idx,
  output logic [IDX_W-1:0]        best_idx
`ifdef MNIST_SCORE_OUT_EN
  ,
  output logic signed [ACC_W-1:0] best_score
`endif
);

  logic signed [ACC_W-1:0] best;

  // Strictly-greater replacement keeps ties on the lowest index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best     <= '0;
      best_idx <= '0;
    end else if (cmp_en && (init || (score > best))) begin
      best     <= score;
      best_idx <= idx;
    end
  end

`ifdef MNIST_SCORE_OUT_EN
  assign best_score = best;
`endif

endmodule

// File: rtl/mnist_mac_sequencer.sv
// Controller for the binarized single-layer MNIST classifier.
// Loads a thresholded pixel frame, streams N_CLASS*N_PIX weights through a
// shared signed accumulator, and reports the argmax class.
//   clk, rst           : clock, async active-high reset
//   start              : begin a frame (honoured in IDLE or DONE)
//   in_valid/in_data   : pixel byte stream, in_ready high in LOAD
//   w_en/w_addr/w_data : weight read port, data returned one cycle after w_en
//   busy               : LOAD or COMPUTE
//   result_valid/class : DONE and winning class, result_ack releases to IDLE
//   result_score       : winning score, present with MNIST_SCORE_OUT_EN
module mnist_mac_sequencer
  import mnist_pkg::*;
#(
  parameter int unsigned N_PIX   = N_PIX_DEF,
  parameter int unsigned N_CLASS = N_CLASS_DEF,
  parameter int unsigned W_W     = W_W_DEF,
  parameter int unsigned THRESH  = THRESH_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 in_valid,
  input  logic [7:0]                           in_data,
  output logic                                 in_ready,
  output logic                                 w_en,
  output logic [$clog2(N_CLASS*N_PIX)-1:0]     w_addr,
  input  logic [W_W-1:0]                       w_data,
  output logic                                 busy,
  output logic                                 result_valid,
  output logic [3:0]                           result_class,
  input  logic                                 result_ack
`ifdef MNIST_SCORE_OUT_EN
  ,
  output logic signed [acc_width(W_W, N_PIX)-1:0] result_score
`endif
);

  localparam int unsigned ACC_W = acc_width(W_W, N_PIX);
  localparam int unsigned AW    = $clog2(N_CLASS * N_PIX);
  localparam int unsigned CW    = $clog2(N_PIX + 1);
  localparam int unsigned PW    = $clog2(N_PIX);

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [3:0]              cls;
  logic [N_PIX-1:0]        pix;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_next;
  logic                    last_tap;

  // Weight returned this cycle belongs to pixel cnt-1; cnt==0 starts a class.
  always_comb begin
    term     = pix[PW'(cnt - CW'(1))] ? ACC_W'($signed(w_data)) : '0;
    acc_next = (cnt == '0) ? '0 : acc + term;
  end

  assign last_tap = (state == COMPUTE) && (cnt == CW'(N_PIX));

  // FSM, counters, pixel register, accumulator and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      w_en         <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      w_addr       <= '0;
      cnt          <= '0;
      cls          <= '0;
      pix          <= '0;
      acc          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
          end
        end
        LOAD: begin
          // in_ready is constantly high here, so in_valid alone is the handshake.
          if (in_valid) begin
            pix[PW'(cnt)] <= ({1'b0, in_data} >= 9'(THRESH));
            if (cnt == CW'(N_PIX - 1)) begin
              state    <= COMPUTE;
              in_ready <= 1'b0;
              cnt      <= '0;
              cls      <= '0;
              w_en     <= 1'b1;
              w_addr   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        COMPUTE: begin
          acc <= acc_next;
          if (cnt == CW'(N_PIX)) begin
            if (cls == 4'(N_CLASS - 1)) begin
              state        <= DONE;
              busy         <= 1'b0;
              result_valid <= 1'b1;
            end else begin
              cls    <= cls + 4'd1;
              cnt    <= '0;
              w_en   <= 1'b1;
              w_addr <= w_addr + AW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(N_PIX - 1)) w_en <= 1'b0;
            else                        w_addr <= w_addr + AW'(1);
          end
        end
        DONE: begin
          if (start) begin
            state        <= LOAD;
            result_valid <= 1'b0;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            cnt          <= '0;
          end else if (result_ack) begin
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mnist_argmax_tracker #(
    .ACC_W (ACC_W),
    .IDX_W (4)
  ) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .init       (last_tap && (cls == 4'd0)),
    .cmp_en     (last_tap),
    .score      (acc_next),
    .idx        (cls),
    .best_idx   (result_class)
`ifdef MNIST_SCORE_OUT_EN
    ,
    .best_score (result_score)
`endif
  );

endmodule
